// File: rtl/npu_exc_commit_ctrl_if.sv
// Commit-side exception bus: MEM-stage cause/PC in, flush/redirect/CP0 update out.
// The slave side belongs to the commit controller; the master side drives it.
interface npu_exc_commit_ctrl_if;
    typedef struct packed {
        logic Interrupt;
        logic WrongAddressinIF;
        logic TLBRefillinIF;
        logic TLBInvalidinIF;
        logic CoprocessorUnusable;
        logic ReservedInstruction;
        logic Syscall;
        logic Break;
        logic Overflow;
        logic Trap;
        logic RdWrongAddressinMEM;
        logic WrWrongAddressinMEM;
        logic RdTLBRefillinMEM;
        logic RdTLBInvalidinMEM;
        logic WrTLBRefillinMEM;
        logic WrTLBInvalidinMEM;
        logic TLBModified;
        logic Eret;
        logic Refetch;
    } ExceptinPipeType;

    logic            MEM_Valid;
    ExceptinPipeType MEM_ExceptType;
    logic [31:0]     MEM_PC;
    logic            MEM_IsInDelaySlot;
    logic [31:0]     MEM_DataAddr;
    logic            CP0_BEV;
    logic [31:0]     CP0_EPC;
    logic            DCache_Busy;
    logic            Redirect_Ready;
    logic            Busy;
    logic            Flush;
    logic            Redirect_Valid;
    logic [31:0]     Redirect_PC;
    logic            CP0_ExcWe;
    logic [4:0]      CP0_ExcCode;
    logic [31:0]     CP0_EPCWdata;
    logic            CP0_BD;
    logic            CP0_BadVAddrWe;
    logic [31:0]     CP0_BadVAddr;
    logic            CP0_EretWe;

    modport slave (
        input  MEM_Valid, MEM_ExceptType, MEM_PC, MEM_IsInDelaySlot,
        input  MEM_DataAddr, CP0_BEV, CP0_EPC, DCache_Busy, Redirect_Ready,
        output Busy, Flush, Redirect_Valid, Redirect_PC,
        output CP0_ExcWe, CP0_ExcCode, CP0_EPCWdata, CP0_BD,
        output CP0_BadVAddrWe, CP0_BadVAddr, CP0_EretWe
    );

    modport master (
        output MEM_Valid, MEM_ExceptType, MEM_PC, MEM_IsInDelaySlot,
        output MEM_DataAddr, CP0_BEV, CP0_EPC, DCache_Busy, Redirect_Ready,
        input  Busy, Flush, Redirect_Valid, Redirect_PC,
        input  CP0_ExcWe, CP0_ExcCode, CP0_EPCWdata, CP0_BD,
        input  CP0_BadVAddrWe, CP0_BadVAddr, CP0_EretWe
    );
endinterface

// File: rtl/npu_exc_commit_ctrl.sv
// Exception/Eret/Refetch commit sequencer: drain D-side, flush pipe,
// update CP0 once, then hand the new fetch target to IF.
module npu_exc_commit_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] REFILL_OFS   = 32'h0000_0000,
    parameter logic [31:0] GENERAL_OFS  = 32'h0000_0180
) (
    input logic clk,
    input logic resetn,
    npu_exc_commit_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        REDIRECT
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;

    logic [18:0] flags_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic [31:0] epc_q;
    logic        bd_q;
    logic        bev_q;

    logic [18:0] flags_in;
    logic        take;
    logic        first;

    // Cause decode state (from latched flags)
    logic [18:0] pri;
    logic [18:0] oh;
    logic [4:0]  code;
    logic        exc;
    logic        eret;
    logic        refetch;
    logic        bv_pc;
    logic        bv_da;
    logic        refill;

    logic [31:0] base;
    logic [31:0] target;
    logic [31:0] epc_wr;

    assign flags_in = bus.MEM_ExceptType;
    assign take     = (state == IDLE) && bus.MEM_Valid && (|flags_in);
    assign first    = (state == FLUSH) && (cnt == CNT_INIT);

    // Interrupt sits in the MSB; reverse so bit 0 is the highest priority
    always_comb begin
        pri = '0;
        for (int i = 0; i < 19; i++) begin
            pri[i] = flags_q[18-i];
        end
        oh = pri & (~pri + 19'd1);
    end

    always_comb begin
        code    = '0;
        exc     = 1'b0;
        eret    = 1'b0;
        refetch = 1'b0;
        bv_pc   = 1'b0;
        bv_da   = 1'b0;
        refill  = 1'b0;
        unique case (1'b1)
            oh[0]: begin
                exc  = 1'b1;
                code = 5'd0;
            end
            oh[1]: begin
                exc   = 1'b1;
                code  = 5'd4;
                bv_pc = 1'b1;
            end
            oh[2]: begin
                exc    = 1'b1;
                code   = 5'd2;
                bv_pc  = 1'b1;
                refill = 1'b1;
            end
            oh[3]: begin
                exc   = 1'b1;
                code  = 5'd2;
                bv_pc = 1'b1;
            end
            oh[4]: begin
                exc  = 1'b1;
                code = 5'd11;
            end
            oh[5]: begin
                exc  = 1'b1;
                code = 5'd10;
            end
            oh[6]: begin
                exc  = 1'b1;
                code = 5'd8;
            end
            oh[7]: begin
                exc  = 1'b1;
                code = 5'd9;
            end
            oh[8]: begin
                exc  = 1'b1;
                code = 5'd12;
            end
            oh[9]: begin
                exc  = 1'b1;
                code = 5'd13;
            end
            oh[10]: begin
                exc   = 1'b1;
                code  = 5'd4;
                bv_da = 1'b1;
            end
            oh[11]: begin
                exc   = 1'b1;
                code  = 5'd5;
                bv_da = 1'b1;
            end
            oh[12]: begin
                exc    = 1'b1;
                code   = 5'd2;
                bv_da  = 1'b1;
                refill = 1'b1;
            end
            oh[13]: begin
                exc   = 1'b1;
                code  = 5'd2;
                bv_da = 1'b1;
            end
            oh[14]: begin
                exc    = 1'b1;
                code   = 5'd3;
                bv_da  = 1'b1;
                refill = 1'b1;
            end
            oh[15]: begin
                exc   = 1'b1;
                code  = 5'd3;
                bv_da = 1'b1;
            end
            oh[16]: begin
                exc   = 1'b1;
                code  = 5'd1;
                bv_da = 1'b1;
            end
            oh[17]: eret = 1'b1;
            oh[18]: refetch = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        base   = bev_q ? 32'hBFC0_0200 : 32'h8000_0000;
        epc_wr = bd_q ? (pc_q - 32'd4) : pc_q;
        if (eret) begin
            target = epc_q;
        end else if (refetch) begin
            target = pc_q;
        end else begin
            target = base + (refill ? REFILL_OFS : GENERAL_OFS);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (take) state_nx = DRAIN;
            end
            DRAIN: begin
                if (!bus.DCache_Busy) begin
                    state_nx = FLUSH;
                    cnt_nx   = CNT_INIT;
                end
            end
            FLUSH: begin
                if (cnt == 4'd0) state_nx = REDIRECT;
                else cnt_nx = cnt - 4'd1;
            end
            REDIRECT: begin
                if (bus.Redirect_Ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flags_q <= '0;
            pc_q    <= '0;
            addr_q  <= '0;
            epc_q   <= '0;
            bd_q    <= 1'b0;
            bev_q   <= 1'b0;
        end else if (take) begin
            flags_q <= flags_in;
            pc_q    <= bus.MEM_PC;
            addr_q  <= bus.MEM_DataAddr;
            epc_q   <= bus.CP0_EPC;
            bd_q    <= bus.MEM_IsInDelaySlot;
            bev_q   <= bus.CP0_BEV;
        end
    end

    // Take-cycle stall is combinational; keep it quiet while held in reset
    assign bus.Busy           = (state != IDLE) || (take && resetn);
    assign bus.Flush          = (state == FLUSH);
    assign bus.Redirect_Valid = (state == REDIRECT);
    assign bus.Redirect_PC    = (state == REDIRECT) ? target : '0;

    assign bus.CP0_ExcWe      = first && exc;
    assign bus.CP0_ExcCode    = (first && exc) ? code : '0;
    assign bus.CP0_EPCWdata   = (first && exc) ? epc_wr : '0;
    assign bus.CP0_BD         = first && exc && bd_q;
    assign bus.CP0_BadVAddrWe = first && (bv_pc || bv_da);
    assign bus.CP0_BadVAddr   = !first ? '0 :
                                bv_pc ? pc_q :
                                bv_da ? addr_q : '0;
    assign bus.CP0_EretWe     = first && eret;

endmodule

// File: tb/tb_npu_exc_commit_ctrl.sv
// Randomized transaction-level bench for the exception commit sequencer.
// A cause-table model predicts CP0 writes, redirect target and phase lengths.
module tb_npu_exc_commit_ctrl;

    localparam int FC = 2;

    // Bit positions in the 19-bit cause vector (Interrupt is the MSB)
    localparam int B_SYS   = 12;
    localparam int B_OV    = 10;
    localparam int B_RDREF = 6;
    localparam int B_WRREF = 4;
    localparam int B_ERET  = 1;
    localparam int B_REF   = 0;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    npu_exc_commit_ctrl_if bus ();

    npu_exc_commit_ctrl #(
        .FLUSH_CYCLES(FC),
        .REFILL_OFS  (32'h0000_0000),
        .GENERAL_OFS (32'h0000_0180)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        excwe;
        logic [4:0]  code;
        logic [31:0] epcw;
        logic        bd;
        logic        bvwe;
        logic [31:0] bv;
        logic        eretwe;
        logic [31:0] rpc;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Cause table in priority order: index 0 = Interrupt .. 18 = Refetch
    function automatic exp_t model(input logic [18:0] f, input logic [31:0] pc,
                                   input logic ds, input logic [31:0] da,
                                   input logic bev, input logic [31:0] epc);
        int unsigned codes [0:16];
        exp_t e;
        int p;
        logic [31:0] base;
        logic refill;
        codes = '{0, 4, 2, 2, 11, 10, 8, 9, 12, 13, 4, 5, 2, 2, 3, 3, 1};
        p = 19;
        for (int i = 0; i < 19; i++) if (f[i]) p = 18 - i;
        e.excwe  = (p < 17);
        e.code   = (p < 17) ? 5'(codes[p]) : 5'd0;
        e.epcw   = ds ? pc - 32'd4 : pc;
        e.bd     = ds;
        e.bvwe   = (p >= 1 && p <= 3) || (p >= 10 && p <= 16);
        e.bv     = (p <= 3) ? pc : da;
        e.eretwe = (p == 17);
        refill   = (p == 2) || (p == 12) || (p == 14);
        base     = bev ? 32'hBFC0_0200 : 32'h8000_0000;
        if (p == 17) e.rpc = epc;
        else if (p == 18) e.rpc = pc;
        else e.rpc = base + (refill ? 32'h0 : 32'h180);
        return e;
    endfunction

    task automatic scramble();
        bus.MEM_Valid         = 1'($urandom);
        bus.MEM_ExceptType    = 19'($urandom);
        bus.MEM_PC            = $urandom;
        bus.MEM_IsInDelaySlot = 1'($urandom);
        bus.MEM_DataAddr      = $urandom;
        bus.CP0_BEV           = 1'($urandom);
        bus.CP0_EPC           = $urandom;
    endtask

    task automatic drive_take(input logic [18:0] f, input logic [31:0] pc,
                              input logic ds, input logic [31:0] da,
                              input logic bev, input logic [31:0] epc);
        @(posedge clk);
        #1;
        bus.MEM_Valid         = 1'b1;
        bus.MEM_ExceptType    = f;
        bus.MEM_PC            = pc;
        bus.MEM_IsInDelaySlot = ds;
        bus.MEM_DataAddr      = da;
        bus.CP0_BEV           = bev;
        bus.CP0_EPC           = epc;
        #2;
        chk("take_busy", 32'(bus.Busy), 32'd1);
    endtask

    task automatic run_txn(input string nm, input logic [18:0] f,
                           input logic [31:0] pc, input logic ds,
                           input logic [31:0] da, input logic bev,
                           input logic [31:0] epc, input int nbusy,
                           input int nwait);
        exp_t e;
        int nd, nf, nr, np, ov, cyc;
        logic done, unstable;
        logic [31:0] rpc0;
        logic c_exc, c_bd, c_bvwe, c_eret;
        logic [4:0] c_code;
        logic [31:0] c_epcw, c_bv;
        e = model(f, pc, ds, da, bev, epc);
        nd = 0; nf = 0; nr = 0; np = 0; ov = 0; cyc = 0;
        done = 1'b0; unstable = 1'b0; rpc0 = '0;
        c_exc = 0; c_bd = 0; c_bvwe = 0; c_eret = 0;
        c_code = '0; c_epcw = '0; c_bv = '0;
        drive_take(f, pc, ds, da, bev, epc);
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            scramble();
            bus.DCache_Busy    = (nd < nbusy);
            bus.Redirect_Ready = (nr >= nwait);
            #2;
            if (bus.Flush && bus.Redirect_Valid) ov++;
            if (bus.CP0_ExcWe || bus.CP0_EretWe || bus.CP0_BadVAddrWe) np++;
            if (bus.Flush) begin
                if (nf == 0) begin
                    c_exc  = bus.CP0_ExcWe;
                    c_code = bus.CP0_ExcCode;
                    c_epcw = bus.CP0_EPCWdata;
                    c_bd   = bus.CP0_BD;
                    c_bvwe = bus.CP0_BadVAddrWe;
                    c_bv   = bus.CP0_BadVAddr;
                    c_eret = bus.CP0_EretWe;
                end
                nf++;
            end else if (bus.Redirect_Valid) begin
                if (nr == 0) rpc0 = bus.Redirect_PC;
                else if (bus.Redirect_PC !== rpc0) unstable = 1'b1;
                if (bus.Redirect_Ready) done = 1'b1;
                nr++;
            end else if (bus.Busy) begin
                nd++;
            end else begin
                done = 1'b1;
            end
            cyc++;
        end
        if (cyc >= 200) chk({nm, "_timeout"}, 32'd1, 32'd0);
        @(posedge clk);
        #1;
        bus.MEM_Valid = 1'b0;
        #2;
        chk({nm, "_busy_drop"}, 32'(bus.Busy), 32'd0);
        chk({nm, "_drain_len"}, 32'(nd), 32'(nbusy + 1));
        chk({nm, "_flush_len"}, 32'(nf), 32'(FC));
        chk({nm, "_redir_len"}, 32'(nr), 32'(nwait + 1));
        chk({nm, "_overlap"}, 32'(ov), 32'd0);
        chk({nm, "_rpc_stable"}, 32'(unstable), 32'd0);
        chk({nm, "_rpc"}, rpc0, e.rpc);
        chk({nm, "_pulses"}, 32'(np), 32'((e.excwe || e.eretwe) ? 1 : 0));
        chk({nm, "_excwe"}, 32'(c_exc), 32'(e.excwe));
        chk({nm, "_eretwe"}, 32'(c_eret), 32'(e.eretwe));
        chk({nm, "_bvwe"}, 32'(c_bvwe), 32'(e.bvwe));
        if (e.excwe) begin
            chk({nm, "_code"}, 32'(c_code), 32'(e.code));
            chk({nm, "_epcw"}, c_epcw, e.epcw);
            chk({nm, "_bd"}, 32'(c_bd), 32'(e.bd));
        end
        if (e.bvwe) chk({nm, "_bv"}, c_bv, e.bv);
    endtask

    task automatic chk_outs_zero(input string nm);
        chk({nm, "_ctl"}, 32'({bus.Busy, bus.Flush, bus.Redirect_Valid,
                                bus.CP0_ExcWe, bus.CP0_EretWe,
                                bus.CP0_BadVAddrWe, bus.CP0_BD}), 32'd0);
        chk({nm, "_data"}, bus.Redirect_PC | bus.CP0_EPCWdata |
                            bus.CP0_BadVAddr | 32'(bus.CP0_ExcCode), 32'd0);
    endtask

    task automatic run_abort();
        int cyc;
        logic seen;
        cyc = 0;
        seen = 1'b0;
        drive_take(19'(1) << B_REF, 32'h8000_4000, 1'b0, 32'h0, 1'b0, 32'h0);
        while (!seen && cyc < 50) begin
            @(posedge clk);
            #1;
            scramble();
            bus.DCache_Busy    = 1'b0;
            bus.Redirect_Ready = 1'b1;
            #2;
            if (bus.CP0_ExcWe || bus.CP0_EretWe || bus.CP0_BadVAddrWe)
                chk("abort_pulse", 32'd1, 32'd0);
            if (bus.Flush) seen = 1'b1;
            cyc++;
        end
        chk("abort_reached_flush", 32'(seen), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk_outs_zero("abort_rst");
        @(negedge clk);
        bus.MEM_Valid = 1'b0;
        resetn = 1'b1;
        @(posedge clk);
        #3;
        chk("abort_idle_busy", 32'(bus.Busy), 32'd0);
        chk("abort_idle_flush", 32'(bus.Flush), 32'd0);
    endtask

    initial begin
        logic [18:0] f;
        bus.MEM_Valid         = 1'b1;
        bus.MEM_ExceptType    = 19'(1) << B_SYS;
        bus.MEM_PC            = 32'h8000_1000;
        bus.MEM_IsInDelaySlot = 1'b1;
        bus.MEM_DataAddr      = 32'h1234_5678;
        bus.CP0_BEV           = 1'b0;
        bus.CP0_EPC           = 32'h0;
        bus.DCache_Busy       = 1'b0;
        bus.Redirect_Ready    = 1'b0;
        #12;
        chk_outs_zero("reset");
        @(negedge clk);
        bus.MEM_Valid = 1'b0;
        resetn = 1'b1;
        @(posedge clk);
        #3;
        chk("idle_busy", 32'(bus.Busy), 32'd0);

        run_txn("sys", 19'(1) << B_SYS, 32'h8000_1000, 1'b0, 32'h0,
                1'b0, 32'h0, 0, 0);
        run_txn("ov_ds", 19'(1) << B_OV, 32'h8000_2004, 1'b1, 32'h0,
                1'b0, 32'h0, 0, 0);
        run_txn("ov_ref", (19'(1) << B_OV) | (19'(1) << B_RDREF),
                32'h8000_5000, 1'b0, 32'h0040_0000, 1'b1, 32'h0, 0, 0);
        run_txn("wrref", 19'(1) << B_WRREF, 32'h8000_6000, 1'b0,
                32'h0040_0000, 1'b0, 32'h0, 4, 0);
        run_txn("eret", 19'(1) << B_ERET, 32'h8000_7000, 1'b0, 32'h0,
                1'b0, 32'h8000_3000, 0, 3);
        run_abort();
        run_txn("sys2", 19'(1) << B_SYS, 32'h8000_8000, 1'b0, 32'h0,
                1'b1, 32'h0, 1, 1);

        for (int t = 0; t < 80; t++) begin
            f = '0;
            for (int k = 0; k <= int'($urandom_range(2, 0)); k++)
                f[$urandom_range(18, 0)] = 1'b1;
            run_txn("rnd", f, $urandom, 1'($urandom), $urandom,
                    1'($urandom), $urandom,
                    int'($urandom_range(6, 0)), int'($urandom_range(3, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
